// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared sizing and pointer type for the register-file FIFO control stage.
package fifo_ctrl_pkg;
  localparam int FIFO_ADR_W = 3;
  localparam int FIFO_DEPTH = 2 ** FIFO_ADR_W;
  typedef logic [FIFO_ADR_W:0] fifo_ptr_t;
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: enabled incrementing pointer whose top bit is the wrap flag toggled on carry-out.
module fifo_wrap_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int ADR_W = FIFO_ADR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [ADR_W-1:0] adr_o,
  output logic             wrap_o
);
  logic [ADR_W:0] ptr_q, ptr_d;
  // carry out of the address field lands in the wrap bit
  always_comb ptr_d = ptr_q + (ADR_W+1)'(en_i);
  always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
  assign {wrap_o, adr_o} = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO pointer/accept/status control; sticky overflow/underflow built only with FIFO_CTRL_ERR_EN.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADR_W = FIFO_ADR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [2**ADR_W-1:0]   wr_load,
  output logic [ADR_W-1:0]      rd_adr,
  output logic                  full,
  output logic                  empty,
  output logic [ADR_W:0]        count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [ADR_W-1:0] wr_adr;
  logic wr_wrap, rd_wrap, wr_acc, rd_acc, same_adr;
  fifo_wrap_ptr #(.ADR_W(ADR_W)) u_wr_ptr (
    .clk(clk), .reset(reset), .en_i(wr_acc), .adr_o(wr_adr), .wrap_o(wr_wrap)
  );
  fifo_wrap_ptr #(.ADR_W(ADR_W)) u_rd_ptr (
    .clk(clk), .reset(reset), .en_i(rd_acc), .adr_o(rd_adr), .wrap_o(rd_wrap)
  );
  assign same_adr = wr_adr == rd_adr;
  assign empty = same_adr & (wr_wrap == rd_wrap);
  assign full = same_adr & (wr_wrap != rd_wrap);
  assign count = {wr_wrap, wr_adr} - {rd_wrap, rd_adr};
  // no bypass: a pop on empty is refused even alongside an accepted push
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_load = (wr_acc & ~reset) ? (2**ADR_W)'(1) << wr_adr : '0;
`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk) begin
    ovf_q <= reset ? 1'b0 : ovf_q | (wr_en & ~wr_acc);
    udf_q <= reset ? 1'b0 : udf_q | (rd_en & ~rd_acc);
  end
  assign overflow = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed vectors for fifo_ctrl; error-flag expectations follow FIFO_CTRL_ERR_EN.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0, reset, wr_en, rd_en;
  logic [FIFO_DEPTH-1:0] wr_load;
  logic [FIFO_ADR_W-1:0] rd_adr;
  logic full, empty, overflow, underflow;
  fifo_ptr_t count;
  int n_vec = 0, n_err = 0;
  fifo_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .wr_load(wr_load),
    .rd_adr(rd_adr), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [31:0] exp_load);
    wr_en = w;
    rd_en = r;
    #1 chk("wr_load", 32'(wr_load), exp_load);
    @(negedge clk);
  endtask
  task automatic status(input int c, input logic f, input logic e, input int ra);
    chk("count", 32'(count), 32'(c));
    chk("full", 32'(full), 32'(f));
    chk("empty", 32'(empty), 32'(e));
    chk("rd_adr", 32'(rd_adr), 32'(ra));
  endtask
  initial begin
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    #1 chk("rst_load", 32'(wr_load), 0);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    status(0, 0, 1, 0);
    chk("idle_load", 32'(wr_load), 0);
    chk("ovf0", 32'(overflow), 0);
    chk("udf0", 32'(underflow), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 32'h1 << i);
      status(i + 1, i == 7, 0, 0);
    end
    cyc(1, 0, 0);
    status(8, 1, 0, 0);
    chk("ovf_full", 32'(overflow), 32'(ERR));
    // push+pop while full: write pointer already wrapped to slot 0
    cyc(1, 1, 32'h01);
    status(8, 1, 0, 1);
    chk("udf_full", 32'(underflow), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      status(7 - i, 0, i == 7, (2 + i) % 8);
    end
    chk("udf_drain", 32'(underflow), 0);
    cyc(1, 1, 32'h02);
    status(1, 0, 0, 1);
    chk("udf_empty", 32'(underflow), 32'(ERR));
    cyc(0, 1, 0);
    status(0, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h1 << (2 + i));
      status(i + 1, 0, 0, 2);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      status(4 - i, 0, i == 4, 3 + i);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 32'h1 << ((7 + i) % 8));
      status(i + 1, i == 7, 0, 7);
    end
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    status(6, 0, 0, 1);
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    #1 chk("rst_mid_load", 32'(wr_load), 0);
    @(negedge clk);
    status(0, 0, 1, 0);
    chk("ovf_rst", 32'(overflow), 0);
    chk("udf_rst", 32'(underflow), 0);
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    cyc(1, 0, 32'h01);
    status(1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
